seg_digit_scanner: RTL and testbench
====================================

// Module: seg_digit_scanner
// PURPOSE
//  Time-multiplexed scan controller that sits directly upstream of seven_seg.
//  - Accepts a packed multi-digit value over a valid/ready handshake.
//  - Presents one 3-bit digit code per slot on digit_code, which drives seven_seg.in.
//  - Drives one-hot, active-low digit enables, with a dead-time gap between digits to stop ghosting.
// PARAMETERS
//  NUM_DIGITS   4      number of display digits, >=2
//  CODE_W       3      bits per digit code; matches the seven_seg input width
//  REFRESH_DIV  50000  clocks per digit slot, including the gap; > DEAD_CYCLES
//  DEAD_CYCLES  8      clocks per slot with all digits off; 0 = no gap
//  LZ_SUPPRESS  1      1 = blank leading zero-code digits; digit 0 is never blanked
// PORTS
//  clk          in   1                  rising-edge clock
//  rst_n        in   1                  asynchronous, active-low reset
//  enable       in   1                  1 = scan, 0 = display off
//  load_valid   in   1                  load_data is valid
//  load_ready   out  1                  pending buffer is empty; load can be accepted
//  load_data    in   NUM_DIGITS*CODE_W  digit i occupies bits [i*CODE_W +: CODE_W]
//  digit_code   out  CODE_W             code of the active digit, to seven_seg.in
//  digit_sel_n  out  NUM_DIGITS         active-low one-hot digit enable
//  frame_done   out  1                  1-cycle pulse on wrap from the last digit to digit 0
// BEHAVIOUR
//  Reset (async assert, sync deassert at the board level)
//  - digit_code=0, digit_sel_n=all 1s, load_ready=1, frame_done=0.
//  - Display register=0, pending empty, idx=0, prescaler=0, state IDLE.
//  Handshake
//  - A transfer occurs when load_valid && load_ready at a clock edge; the data goes to the pending register.
//  - load_ready=0 from the next cycle until the pending data is applied.
//  Apply
//  - With enable=1, pending data is copied to the display register on the wrap edge.
//  - With enable=0, pending data is applied on the next edge.
//  - load_ready returns to 1 the cycle after apply.
//  - A frame in progress always finishes with the old data.
//  States: IDLE, ON, GAP
//  - IDLE: digit_sel_n=all 1s, prescaler held at 0.
//    enable=1 -> ON, idx=0, digit 0 driven on the next edge.
//  - ON: active digit low, except blanked digits stay 1; lasts REFRESH_DIV-DEAD_CYCLES cycles.
//    Then -> GAP. If DEAD_CYCLES=0, go straight to the next digit's ON.
//  - GAP: digit_sel_n=all 1s for DEAD_CYCLES cycles, then -> ON.
//  Digit advance (on the GAP->ON or ON->ON edge)
//  - idx, digit_code and digit_sel_n update on the same edge, all registered, so code and enable never skew.
//  - idx wraps NUM_DIGITS-1 -> 0. frame_done pulses and pending is applied on that same edge.
//  Leading-zero blanking (LZ_SUPPRESS=1)
//  - Digit i>0 is blanked if it and every higher digit hold code 0.
//  - A blanked slot keeps its timing but its enable stays 1.
//  enable=0 in ON or GAP
//  - Next edge: IDLE, all enables off, idx=0, prescaler=0.
//  - A pending load stays held until it is applied.
//  Reset mid-operation: all state is cleared immediately and any pending data is discarded.
//  Sizing
//  - Prescaler width is $clog2(REFRESH_DIV).
//  - idx width is $clog2(NUM_DIGITS).
// STRUCTURE
//  - seg_pkg: CODE_W default, the scan_state_t enum {IDLE, ON, GAP}, and localparam ANODE_OFF.
//  - One sub-module, seg_tick_gen: the prescaler.
//    Outputs slot_end and gap_start pulses; cleared by its own clr input.
// TESTING (bench: REFRESH_DIV=4, DEAD_CYCLES=1, NUM_DIGITS=4, LZ_SUPPRESS=0)
//  - Basic scan: load 12'b011_010_001_000, enable=1.
//    -> digit_sel_n runs 1110, 1101, 1011, 0111, each for 3 cycles, with 1111 for 1 cycle between them.
//    -> digit_code runs 0, 1, 2, 3; frame_done pulses on the 3->0 wrap.
//  - Load mid-frame during digit 1: load 12'b000_000_000_011.
//    -> load_ready=0 until the wrap; digits 2 and 3 still show 2 and 3.
//    -> The next frame's digit 0 shows 3, and load_ready returns to 1 one cycle after the wrap.
//  - Leading-zero blanking, LZ_SUPPRESS=1: data digits 3..0 = 0,0,0,2.
//    -> The slots for digits 3..1 hold 1111; digit 0 shows code 2.
//    -> All-zero data shows code 0 on digit 0 only.
//  - Enable drop: enable=0 during digit 2.
//    -> Next edge digit_sel_n=1111.
//    -> After enable=1, scanning restarts at digit 0 and frame_done does not pulse.
//  - Asynchronous reset: rst_n low mid-slot with a load pending.
//    -> Outputs reach their reset values without waiting for a clock; load_ready=1; the pending data is lost.
//  - No gap, DEAD_CYCLES=0.
//    -> Digits run back to back with 4 cycles each and no 1111 cycle between them.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment digit scanner.
// ANODE_OFF is the inactive level of a digit enable line.
package seg_pkg;

    localparam int DEFAULT_CODE_W = 3;
    localparam logic ANODE_OFF = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Slot prescaler for the digit scanner: counts clocks within one digit slot,
// flags the last ON cycle (gap_start_o) and the last cycle of the slot (slot_end_o).
module seg_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic slot_end_o,
    output logic gap_start_o
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST_CNT = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GAP_CNT  = PW'(REFRESH_DIV - DEAD_CYCLES - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    assign slot_end_o  = (cnt_q == LAST_CNT);
    assign gap_start_o = (DEAD_CYCLES > 0) && (cnt_q == GAP_CNT);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || slot_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_digit_scanner.sv
// Time-multiplexed scan controller feeding seven_seg: buffers one pending value,
// swaps it in at frame boundaries, and drives registered code/enable pairs with dead time.
module seg_digit_scanner
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CODE_W      = DEFAULT_CODE_W,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 8,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [NUM_DIGITS*CODE_W-1:0] load_data,
    output logic [CODE_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]        digit_sel_n,
    output logic                         frame_done
);

    localparam int DW = NUM_DIGITS * CODE_W;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_OFF  = {NUM_DIGITS{ANODE_OFF}};

    scan_state_t state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [CODE_W-1:0]     code_q, code_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic                  frame_q, frame_d;
    logic [DW-1:0]         disp_q, disp_d;
    logic                  pend_valid_q, pend_valid_d;
    logic [DW-1:0]         pend_data_q, pend_data_d;

    logic          slot_end, gap_start, tick_clr, wrap;
    logic [IW-1:0] next_idx;
    logic [DW-1:0] show_data;

    // A digit is blanked when it and every more significant digit are zero.
    function automatic logic blank_digit(input logic [DW-1:0] data, input logic [IW-1:0] i);
        logic upper_nonzero;
        upper_nonzero = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(i) && data[j*CODE_W +: CODE_W] != '0) begin
                upper_nonzero = 1'b1;
            end
        end
        return (LZ_SUPPRESS != 0) && (i != '0) && !upper_nonzero;
    endfunction

    seg_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (tick_clr),
        .slot_end_o  (slot_end),
        .gap_start_o (gap_start)
    );

    assign tick_clr  = (state_q == IDLE) || !enable;
    assign wrap      = (idx_q == LAST_IDX);
    assign next_idx  = wrap ? '0 : idx_q + 1'b1;
    // On the wrap edge the new frame's digit 0 already comes from the pending value.
    assign show_data = (wrap && pend_valid_q) ? pend_data_q : disp_q;

    assign load_ready  = !pend_valid_q;
    assign digit_code  = code_q;
    assign digit_sel_n = sel_q;
    assign frame_done  = frame_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        code_d       = code_q;
        sel_d        = sel_q;
        frame_d      = 1'b0;
        disp_d       = disp_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;

        if (load_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_data_d  = load_data;
        end
        if (!enable && pend_valid_q) begin
            disp_d       = pend_data_q;
            pend_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ON;
                    idx_d   = '0;
                    code_d  = disp_q[CODE_W-1:0];
                    sel_d   = ~NUM_DIGITS'(1);
                end
            end
            ON, GAP: begin
                if (!enable) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    code_d  = '0;
                    sel_d   = ALL_OFF;
                end else if (slot_end) begin
                    state_d = ON;
                    idx_d   = next_idx;
                    code_d  = show_data[next_idx*CODE_W +: CODE_W];
                    sel_d   = blank_digit(show_data, next_idx) ? ALL_OFF
                                                               : ~(NUM_DIGITS'(1) << next_idx);
                    frame_d = wrap;
                    if (wrap && pend_valid_q) begin
                        disp_d       = pend_data_q;
                        pend_valid_d = 1'b0;
                    end
                end else if (gap_start && state_q == ON) begin
                    state_d = GAP;
                    sel_d   = ALL_OFF;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = ALL_OFF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            code_q       <= '0;
            sel_q        <= ALL_OFF;
            frame_q      <= 1'b0;
            disp_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            code_q       <= code_d;
            sel_q        <= sel_d;
            frame_q      <= frame_d;
            disp_q       <= disp_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: three instances (gap, gap+blanking, no gap) compared
// cycle by cycle against a slot/position arithmetic model of the scan.
module tb_seg_digit_scanner;

    localparam int ND = 4;
    localparam int CW = 3;
    localparam int RD = 4;
    localparam int DW = ND * CW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic          en [3];
    logic          lv [3];
    logic [DW-1:0] ld [3];
    logic          lr [3];
    logic [CW-1:0] code [3];
    logic [ND-1:0] sel [3];
    logic          fd [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seg_digit_scanner #(.NUM_DIGITS(ND), .CODE_W(CW), .REFRESH_DIV(RD), .DEAD_CYCLES(1), .LZ_SUPPRESS(0)) u_gap (
        .clk(clk), .rst_n(rst_n), .enable(en[0]), .load_valid(lv[0]), .load_ready(lr[0]),
        .load_data(ld[0]), .digit_code(code[0]), .digit_sel_n(sel[0]), .frame_done(fd[0]));

    seg_digit_scanner #(.NUM_DIGITS(ND), .CODE_W(CW), .REFRESH_DIV(RD), .DEAD_CYCLES(1), .LZ_SUPPRESS(1)) u_lz (
        .clk(clk), .rst_n(rst_n), .enable(en[1]), .load_valid(lv[1]), .load_ready(lr[1]),
        .load_data(ld[1]), .digit_code(code[1]), .digit_sel_n(sel[1]), .frame_done(fd[1]));

    seg_digit_scanner #(.NUM_DIGITS(ND), .CODE_W(CW), .REFRESH_DIV(RD), .DEAD_CYCLES(0), .LZ_SUPPRESS(0)) u_nogap (
        .clk(clk), .rst_n(rst_n), .enable(en[2]), .load_valid(lv[2]), .load_ready(lr[2]),
        .load_data(ld[2]), .digit_code(code[2]), .digit_sel_n(sel[2]), .frame_done(fd[2]));

    function automatic int dead_of(int u);
        return (u == 2) ? 0 : 1;
    endfunction

    // Cycle k counts from the first ON cycle after enable; slot = k/RD, digit = slot mod ND.
    function automatic logic [ND-1:0] exp_sel(int u, int k, logic [DW-1:0] data);
        int pos;
        int digit;
        pos   = k % RD;
        digit = (k / RD) % ND;
        if (pos >= RD - dead_of(u)) return '1;
        if (u == 1 && digit > 0 && (data >> (digit * CW)) == 0) return '1;
        return ~(ND'(1) << digit);
    endfunction

    function automatic logic [CW-1:0] exp_code(int k, logic [DW-1:0] data);
        logic [DW-1:0] t;
        t = data >> (((k / RD) % ND) * CW);
        return t[CW-1:0];
    endfunction

    function automatic logic exp_fd(int k);
        return (k > 0) && (k % (RD * ND) == 0);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle(int u);
        en[u] = 1'b0;
        lv[u] = 1'b0;
        step;
        step;
    endtask

    task automatic load_apply(int u, logic [DW-1:0] d);
        lv[u] = 1'b1;
        ld[u] = d;
        step;
        lv[u] = 1'b0;
        checks++;
        if (lr[u] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_busy u%0d: load_ready=%b expected 0", u, lr[u]);
        end
        step;
        checks++;
        if (lr[u] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_release u%0d: load_ready=%b expected 1", u, lr[u]);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        #2;
        for (int u = 0; u < 3; u++) begin
            checks += 4;
            if (sel[u] !== '1) begin
                errors++;
                $display("[TB] FAIL reset_sel u%0d: got %b expected 1111", u, sel[u]);
            end
            if (code[u] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_code u%0d: got %0d expected 0", u, code[u]);
            end
            if (lr[u] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_ready u%0d: got %b expected 1", u, lr[u]);
            end
            if (fd[u] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_frame u%0d: got %b expected 0", u, fd[u]);
            end
        end
        #19 rst_n = 1'b1;
    endtask

    task automatic test_basic_scan;
        logic [DW-1:0] d;
        logic [ND-1:0] es;
        d = 12'b011_010_001_000;
        go_idle(0);
        load_apply(0, d);
        en[0] = 1'b1;
        for (int k = 0; k < 2 * RD * ND; k++) begin
            step;
            es = exp_sel(0, k, d);
            checks += 3;
            if (sel[0] !== es) begin
                errors++;
                $display("[TB] FAIL basic_sel k=%0d: got %b expected %b", k, sel[0], es);
            end
            if (fd[0] !== exp_fd(k)) begin
                errors++;
                $display("[TB] FAIL basic_frame k=%0d: got %b expected %b", k, fd[0], exp_fd(k));
            end
            if (lr[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL basic_ready k=%0d: got %b expected 1", k, lr[0]);
            end
            if (es !== '1) begin
                checks++;
                if (code[0] !== exp_code(k, d)) begin
                    errors++;
                    $display("[TB] FAIL basic_code k=%0d: got %0d expected %0d", k, code[0], exp_code(k, d));
                end
            end
        end
    endtask

    task automatic test_load_midframe;
        logic [DW-1:0] d0, d1, dk;
        logic [ND-1:0] es;
        logic          elr;
        int            kload;
        for (int it = 0; it < 2; it++) begin
            d0    = DW'($urandom_range(1, 4095));
            d1    = (it == 0) ? 12'b000_000_000_011 : DW'($urandom);
            kload = RD + $urandom_range(0, RD - 2);
            go_idle(0);
            load_apply(0, d0);
            en[0] = 1'b1;
            for (int k = 0; k < 2 * RD * ND; k++) begin
                step;
                dk  = (k < RD * ND) ? d0 : d1;
                es  = exp_sel(0, k, dk);
                elr = !(k > kload && k < RD * ND);
                checks += 2;
                if (sel[0] !== es) begin
                    errors++;
                    $display("[TB] FAIL mid_sel k=%0d: got %b expected %b", k, sel[0], es);
                end
                if (lr[0] !== elr) begin
                    errors++;
                    $display("[TB] FAIL mid_ready k=%0d: got %b expected %b", k, lr[0], elr);
                end
                if (es !== '1) begin
                    checks++;
                    if (code[0] !== exp_code(k, dk)) begin
                        errors++;
                        $display("[TB] FAIL mid_code k=%0d: got %0d expected %0d", k, code[0], exp_code(k, dk));
                    end
                end
                lv[0] = (k == kload);
                ld[0] = d1;
            end
            lv[0] = 1'b0;
        end
    endtask

    task automatic test_lz_blank;
        logic [DW-1:0] d;
        logic [ND-1:0] es;
        for (int it = 0; it < 6; it++) begin
            if (it == 0)      d = 12'b000_000_000_010;
            else if (it == 1) d = '0;
            else              d = DW'($urandom_range(0, 4095)) >> (CW * $urandom_range(0, ND - 1));
            go_idle(1);
            load_apply(1, d);
            en[1] = 1'b1;
            for (int k = 0; k <= RD * ND; k++) begin
                step;
                es = exp_sel(1, k, d);
                checks += 2;
                if (sel[1] !== es) begin
                    errors++;
                    $display("[TB] FAIL lz_sel data=%03h k=%0d: got %b expected %b", d, k, sel[1], es);
                end
                if (fd[1] !== exp_fd(k)) begin
                    errors++;
                    $display("[TB] FAIL lz_frame k=%0d: got %b expected %b", k, fd[1], exp_fd(k));
                end
                if (es !== '1) begin
                    checks++;
                    if (code[1] !== exp_code(k, d)) begin
                        errors++;
                        $display("[TB] FAIL lz_code data=%03h k=%0d: got %0d expected %0d", d, k, code[1], exp_code(k, d));
                    end
                end
            end
        end
        en[1] = 1'b0;
    endtask

    task automatic test_enable_drop;
        logic [DW-1:0] d;
        logic [ND-1:0] es;
        int            kdrop;
        d     = DW'($urandom);
        kdrop = 2 * RD + $urandom_range(0, RD - 1);
        go_idle(0);
        load_apply(0, d);
        en[0] = 1'b1;
        for (int k = 0; k <= kdrop; k++) begin
            step;
            es = exp_sel(0, k, d);
            checks++;
            if (sel[0] !== es) begin
                errors++;
                $display("[TB] FAIL drop_pre_sel k=%0d: got %b expected %b", k, sel[0], es);
            end
        end
        en[0] = 1'b0;
        step;
        checks += 2;
        if (sel[0] !== '1) begin
            errors++;
            $display("[TB] FAIL drop_off_sel: got %b expected 1111", sel[0]);
        end
        if (fd[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_off_frame: got %b expected 0", fd[0]);
        end
        en[0] = 1'b1;
        for (int k = 0; k <= RD * ND; k++) begin
            step;
            es = exp_sel(0, k, d);
            checks += 2;
            if (sel[0] !== es) begin
                errors++;
                $display("[TB] FAIL drop_restart_sel k=%0d: got %b expected %b", k, sel[0], es);
            end
            if (fd[0] !== exp_fd(k)) begin
                errors++;
                $display("[TB] FAIL drop_restart_frame k=%0d: got %b expected %b", k, fd[0], exp_fd(k));
            end
            if (es !== '1) begin
                checks++;
                if (code[0] !== exp_code(k, d)) begin
                    errors++;
                    $display("[TB] FAIL drop_restart_code k=%0d: got %0d expected %0d", k, code[0], exp_code(k, d));
                end
            end
        end
    endtask

    task automatic test_async_reset;
        logic [DW-1:0] d;
        logic [ND-1:0] es;
        d = DW'($urandom_range(1, 4095));
        go_idle(0);
        load_apply(0, d);
        en[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step;
            lv[0] = (k == 5);
            ld[0] = DW'($urandom_range(1, 4095));
        end
        step;
        lv[0] = 1'b0;
        checks++;
        if (lr[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_pending: load_ready=%b expected 0", lr[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (sel[0] !== '1) begin
            errors++;
            $display("[TB] FAIL areset_sel: got %b expected 1111", sel[0]);
        end
        if (code[0] !== '0) begin
            errors++;
            $display("[TB] FAIL areset_code: got %0d expected 0", code[0]);
        end
        if (lr[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL areset_ready: got %b expected 1", lr[0]);
        end
        if (fd[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL areset_frame: got %b expected 0", fd[0]);
        end
        #2 rst_n = 1'b1;
        for (int k = 0; k <= RD * ND; k++) begin
            step;
            es = exp_sel(0, k, '0);
            checks += 2;
            if (sel[0] !== es) begin
                errors++;
                $display("[TB] FAIL areset_after_sel k=%0d: got %b expected %b", k, sel[0], es);
            end
            if (lr[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL areset_after_ready k=%0d: got %b expected 1", k, lr[0]);
            end
            if (es !== '1) begin
                checks++;
                if (code[0] !== '0) begin
                    errors++;
                    $display("[TB] FAIL areset_after_code k=%0d: got %0d expected 0", k, code[0]);
                end
            end
        end
        en[0] = 1'b0;
    endtask

    task automatic test_no_gap;
        logic [DW-1:0] d;
        logic [ND-1:0] es;
        d = DW'($urandom);
        go_idle(2);
        load_apply(2, d);
        en[2] = 1'b1;
        for (int k = 0; k <= 2 * RD * ND; k++) begin
            step;
            es = exp_sel(2, k, d);
            checks += 3;
            if (sel[2] !== es) begin
                errors++;
                $display("[TB] FAIL nogap_sel k=%0d: got %b expected %b", k, sel[2], es);
            end
            if (code[2] !== exp_code(k, d)) begin
                errors++;
                $display("[TB] FAIL nogap_code k=%0d: got %0d expected %0d", k, code[2], exp_code(k, d));
            end
            if (fd[2] !== exp_fd(k)) begin
                errors++;
                $display("[TB] FAIL nogap_frame k=%0d: got %b expected %b", k, fd[2], exp_fd(k));
            end
        end
        en[2] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            en[u] = 1'b0;
            lv[u] = 1'b0;
            ld[u] = '0;
        end
        test_reset;
        test_basic_scan;
        test_load_midframe;
        test_lz_blank;
        test_enable_drop;
        test_async_reset;
        test_no_gap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
